// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired Moore control unit for CPU_Datapath. Runs a fetch
//               phase (T0-T2), then an execute phase (T3-T7) selected by the
//               opcode latched from IR[31:27] at the T2->T3 edge.
//               Every strobe is decoded from the registered state, the
//               latched opcode and the memory-wait counter. The only
//               exception is the br T6 PC load, which is qualified by CON.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, clr        clock (rising edge), asynchronous active-high reset
//   run             start/continue, sampled in IDLE and in the last
//                   execute state
//   IR[31:0], CON   instruction register and branch condition from datapath
//   PCout..CON_FF_In  datapath strobes, one bit each
//   ALUSelection    ALU op code; ALU_ADD whenever Zin is low
//   halted          high in HALT
//   state           present state: IDLE=0, T0..T7=1..8, HALT=9
// Configuration
//   CTRL_MULDIV_EN  when defined, adds the mul (01111) / div (10000) sequences.
//                   When undefined, both opcodes decode as nop.
// ============================================================================
module control_sequencer #(
  parameter int         MEM_WAIT = 1,
  parameter logic [4:0] ALU_ADD  = 5'b00001,
  parameter logic [4:0] ALU_SUB  = 5'b00010,
  parameter logic [4:0] ALU_AND  = 5'b00011,
  parameter logic [4:0] ALU_OR   = 5'b00100,
  parameter logic [4:0] ALU_MUL  = 5'b01111,
  parameter logic [4:0] ALU_DIV  = 5'b10000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        wren,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        HIin,
  output logic        Loin,
  output logic        HIout,
  output logic        Loout,
  output logic        InPortout,
  output logic        OPin,
  output logic        CON_FF_In,
  output logic [4:0]  ALUSelection,
  output logic        halted,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    IDLE = 5'd0, T0 = 5'd1, T1 = 5'd2, T2 = 5'd3, T3 = 5'd4,
    T4 = 5'd5, T5 = 5'd6, T6 = 5'd7, T7 = 5'd8, HALT = 5'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int                WAIT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);

  state_t            r_state;
  state_t            w_next;
  state_t            w_last;
  logic [4:0]        r_op;
  logic [WAIT_W-1:0] r_wait;
  logic              w_mem_hold;
  logic              w_wait_done;
  logic [4:0]        w_alu_op;

  // These bits are consumed by the datapath, not by the sequencer.
  logic unused_bits;
`ifdef CTRL_MULDIV_EN
  assign unused_bits = ^IR[26:0];
`else
  assign unused_bits = ^{IR[26:0], ALU_MUL, ALU_DIV};
`endif

  // Memory-read states stay put until the counter reaches MEM_WAIT-1.
  assign w_mem_hold  = (r_state == T1) || ((r_state == T6) && (r_op == OP_LD));
  assign w_wait_done = (r_wait == WAIT_LAST);
  assign state       = r_state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_op    <= 5'd0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == T2) r_op <= IR[31:27];
      r_wait  <= (w_mem_hold && !w_wait_done) ? r_wait + 1'b1 : '0;
    end
  end

  // Final execute state for each opcode; anything undecoded ends after T3.
  always_comb begin
    w_last = T3;
    case (r_op)
      OP_LD, OP_ST:                                      w_last = T7;
      OP_BR:                                             w_last = T6;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:                  w_last = T5;
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV:                                    w_last = T6;
`endif
      default:                                           w_last = T3;
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    case (r_op)
      OP_SUB:           w_alu_op = ALU_SUB;
      OP_AND, OP_ANDI:  w_alu_op = ALU_AND;
      OP_OR, OP_ORI:    w_alu_op = ALU_OR;
`ifdef CTRL_MULDIV_EN
      OP_MUL:           w_alu_op = ALU_MUL;
      OP_DIV:           w_alu_op = ALU_DIV;
`endif
      default:          w_alu_op = ALU_ADD;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (run) w_next = T0;
      T0:   w_next = T1;
      T1:   if (w_wait_done) w_next = T2;
      T2:   w_next = T3;
      T3, T4, T5, T6, T7: begin
        if ((r_state == T3) && (r_op == OP_HALT)) begin
          w_next = HALT;
        end else if (w_mem_hold && !w_wait_done) begin
          w_next = r_state;
        end else if (r_state == w_last) begin
          w_next = run ? T0 : IDLE;
        end else begin
          case (r_state)
            T3:      w_next = T4;
            T4:      w_next = T5;
            T5:      w_next = T6;
            T6:      w_next = T7;
            default: w_next = IDLE;
          endcase
        end
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // Strobe decode
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; MDRread = 1'b0; wren = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; HIin = 1'b0; Loin = 1'b0; HIout = 1'b0;
    Loout = 1'b0; InPortout = 1'b0; OPin = 1'b0; CON_FF_In = 1'b0;
    ALUSelection = ALU_ADD;
    halted = (r_state == HALT);
    case (r_state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin
        ZLOout = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
        PCin = w_wait_done;  // PC loads once, on the final wait cycle
      end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3, T4, T5, T6, T7: begin
        case (r_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (r_state)
              T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              T4: begin
                Zin = 1'b1; ALUSelection = w_alu_op;
                if (r_op[3]) Cout = 1'b1;  // immediate forms take C
                else begin Grc = 1'b1; Rout = 1'b1; end
              end
              T5: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_LDI, OP_LD, OP_ST: begin
            case (r_state)
              T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              T4: begin Cout = 1'b1; Zin = 1'b1; end
              T5: begin
                ZLOout = 1'b1;
                if (r_op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                else MARin = 1'b1;
              end
              T6: begin
                MDRin = 1'b1;
                if (r_op == OP_LD) MDRread = 1'b1;
                else begin Gra = 1'b1; Rout = 1'b1; end
              end
              T7: begin
                if (r_op == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else wren = 1'b1;
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (r_state)
              T3: begin Gra = 1'b1; Rout = 1'b1; CON_FF_In = 1'b1; end
              T4: begin PCout = 1'b1; Yin = 1'b1; end
              T5: begin Cout = 1'b1; Zin = 1'b1; end
              T6: begin ZLOout = CON; PCin = CON; end
              default: ;
            endcase
          end
`ifdef CTRL_MULDIV_EN
          OP_MUL, OP_DIV: begin
            case (r_state)
              T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              T4: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUSelection = w_alu_op; end
              T5: begin ZLOout = 1'b1; Loin = 1'b1; end
              T6: begin ZHIout = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
          end
`endif
          OP_JR:   if (r_state == T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_IN:   if (r_state == T3) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  if (r_state == T3) begin Gra = 1'b1; Rout = 1'b1; OPin = 1'b1; end
          OP_MFHI: if (r_state == T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: if (r_state == T3) begin Loout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;  // nop, halt T3 and undecoded opcodes
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. Two instances
//               (MEM_WAIT=1 and MEM_WAIT=3) share IR/CON. Per-cycle expected
//               strobes/state come from a bench-side sequence model via a
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  localparam logic [26:0] M_PCOUT = 27'(1) << 0,  M_PCIN   = 27'(1) << 1,
                          M_INCPC = 27'(1) << 2,  M_MARIN  = 27'(1) << 3,
                          M_MDRIN = 27'(1) << 4,  M_MDROUT = 27'(1) << 5,
                          M_MDRRD = 27'(1) << 6,  M_WREN   = 27'(1) << 7,
                          M_IRIN  = 27'(1) << 8,  M_YIN    = 27'(1) << 9,
                          M_ZIN   = 27'(1) << 10, M_ZLO    = 27'(1) << 11,
                          M_ZHI   = 27'(1) << 12, M_GRA    = 27'(1) << 13,
                          M_GRB   = 27'(1) << 14, M_GRC    = 27'(1) << 15,
                          M_RIN   = 27'(1) << 16, M_ROUT   = 27'(1) << 17,
                          M_BAOUT = 27'(1) << 18, M_COUT   = 27'(1) << 19,
                          M_HIIN  = 27'(1) << 20, M_LOIN   = 27'(1) << 21,
                          M_HIOUT = 27'(1) << 22, M_LOOUT  = 27'(1) << 23,
                          M_INP   = 27'(1) << 24, M_OPIN   = 27'(1) << 25,
                          M_CONFF = 27'(1) << 26;

  localparam logic [4:0] S_IDLE = 5'd0, S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3,
                         S_T3 = 5'd4, S_T4 = 5'd5, S_T5 = 5'd6, S_T6 = 5'd7,
                         S_T7 = 5'd8, S_HALT = 5'd9;

  typedef struct packed {
    logic [26:0] s;
    logic [4:0]  alu;
    logic [4:0]  st;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic        sel = 1'b0;  // 0: MEM_WAIT=1 instance, 1: MEM_WAIT=3 instance
  logic [31:0] ir  = 32'd0;
  logic        con = 1'b0;
  logic        run_a, run_b;
  logic [26:0] s_a, s_b;
  logic [4:0]  alu_a, alu_b, st_a, st_b;
  logic        h_a, h_b;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  assign run_a = run && !sel;
  assign run_b = run && sel;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT(1)) u_dut_a (
    .clk(clk), .clr(clr), .run(run_a), .IR(ir), .CON(con),
    .PCout(s_a[0]), .PCin(s_a[1]), .IncPC(s_a[2]), .MARin(s_a[3]),
    .MDRin(s_a[4]), .MDRout(s_a[5]), .MDRread(s_a[6]), .wren(s_a[7]),
    .IRin(s_a[8]), .Yin(s_a[9]), .Zin(s_a[10]), .ZLOout(s_a[11]),
    .ZHIout(s_a[12]), .Gra(s_a[13]), .Grb(s_a[14]), .Grc(s_a[15]),
    .Rin(s_a[16]), .Rout(s_a[17]), .BAout(s_a[18]), .Cout(s_a[19]),
    .HIin(s_a[20]), .Loin(s_a[21]), .HIout(s_a[22]), .Loout(s_a[23]),
    .InPortout(s_a[24]), .OPin(s_a[25]), .CON_FF_In(s_a[26]),
    .ALUSelection(alu_a), .halted(h_a), .state(st_a)
  );

  control_sequencer #(.MEM_WAIT(3)) u_dut_b (
    .clk(clk), .clr(clr), .run(run_b), .IR(ir), .CON(con),
    .PCout(s_b[0]), .PCin(s_b[1]), .IncPC(s_b[2]), .MARin(s_b[3]),
    .MDRin(s_b[4]), .MDRout(s_b[5]), .MDRread(s_b[6]), .wren(s_b[7]),
    .IRin(s_b[8]), .Yin(s_b[9]), .Zin(s_b[10]), .ZLOout(s_b[11]),
    .ZHIout(s_b[12]), .Gra(s_b[13]), .Grb(s_b[14]), .Grc(s_b[15]),
    .Rin(s_b[16]), .Rout(s_b[17]), .BAout(s_b[18]), .Cout(s_b[19]),
    .HIin(s_b[20]), .Loin(s_b[21]), .HIout(s_b[22]), .Loout(s_b[23]),
    .InPortout(s_b[24]), .OPin(s_b[25]), .CON_FF_In(s_b[26]),
    .ALUSelection(alu_b), .halted(h_b), .state(st_b)
  );

  // ---------------- reference model ----------------
  function automatic logic [4:0] alu_of(input logic [4:0] op);
    case (op)
      5'b00100:           return 5'b00010;
      5'b00101, 5'b01101: return 5'b00011;
      5'b00110, 5'b01110: return 5'b00100;
      5'b01111:           return 5'b01111;
      5'b10000:           return 5'b10000;
      default:            return 5'b00001;
    endcase
  endfunction

  task automatic push(input logic [26:0] s, input logic [4:0] alu, input logic [4:0] st);
    q.push_back({s, alu, st, (st == S_HALT)});
  endtask

  task automatic push_fetch(input int mw);
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd1, S_T0);
    for (int i = 0; i < mw; i++)
      push(M_ZLO | M_MDRRD | M_MDRIN | ((i == mw - 1) ? M_PCIN : 27'd0), 5'd1, S_T1);
    push(M_MDROUT | M_IRIN, 5'd1, S_T2);
  endtask

  // tail: 0 -> ends in IDLE, 1 -> continues into T0, 2 -> nothing appended
  task automatic expect_instr(input logic [4:0] op, input int mw, input logic c, input int tail);
    push_fetch(mw);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(M_GRB | M_ROUT | M_YIN, 5'd1, S_T3);
        push(M_GRC | M_ROUT | M_ZIN, alu_of(op), S_T4);
        push(M_ZLO | M_GRA | M_RIN, 5'd1, S_T5);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        push(M_GRB | M_ROUT | M_YIN, 5'd1, S_T3);
        push(M_COUT | M_ZIN, alu_of(op), S_T4);
        push(M_ZLO | M_GRA | M_RIN, 5'd1, S_T5);
      end
      5'b00000, 5'b00001, 5'b00010: begin
        push(M_GRB | M_BAOUT | M_YIN, 5'd1, S_T3);
        push(M_COUT | M_ZIN, 5'd1, S_T4);
        if (op == 5'b00001) push(M_ZLO | M_GRA | M_RIN, 5'd1, S_T5);
        else push(M_ZLO | M_MARIN, 5'd1, S_T5);
        if (op == 5'b00000) begin
          for (int i = 0; i < mw; i++) push(M_MDRRD | M_MDRIN, 5'd1, S_T6);
          push(M_MDROUT | M_GRA | M_RIN, 5'd1, S_T7);
        end else if (op == 5'b00010) begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd1, S_T6);
          push(M_WREN, 5'd1, S_T7);
        end
      end
      5'b10011: begin
        push(M_GRA | M_ROUT | M_CONFF, 5'd1, S_T3);
        push(M_PCOUT | M_YIN, 5'd1, S_T4);
        push(M_COUT | M_ZIN, 5'd1, S_T5);
        push(c ? (M_ZLO | M_PCIN) : 27'd0, 5'd1, S_T6);
      end
      5'b10100: push(M_GRA | M_ROUT | M_PCIN, 5'd1, S_T3);
      5'b10110: push(M_INP | M_GRA | M_RIN, 5'd1, S_T3);
      5'b10111: push(M_GRA | M_ROUT | M_OPIN, 5'd1, S_T3);
      5'b11000: push(M_HIOUT | M_GRA | M_RIN, 5'd1, S_T3);
      5'b11001: push(M_LOOUT | M_GRA | M_RIN, 5'd1, S_T3);
`ifdef CTRL_MULDIV_EN
      5'b01111, 5'b10000: begin
        push(M_GRA | M_ROUT | M_YIN, 5'd1, S_T3);
        push(M_GRB | M_ROUT | M_ZIN, alu_of(op), S_T4);
        push(M_ZLO | M_LOIN, 5'd1, S_T5);
        push(M_ZHI | M_HIIN, 5'd1, S_T6);
      end
`endif
      default: push(27'd0, 5'd1, S_T3);
    endcase
    if (tail == 0) push(27'd0, 5'd1, S_IDLE);
    else if (tail == 1) push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd1, S_T0);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input string tag, input exp_t e);
    chk({tag, ".strobes"}, 32'(sel ? s_b : s_a), 32'(e.s));
    chk({tag, ".alu"},     32'(sel ? alu_b : alu_a), 32'(e.alu));
    chk({tag, ".state"},   32'(sel ? st_b : st_a), 32'(e.st));
    chk({tag, ".halted"},  32'(sel ? h_b : h_a), 32'(e.h));
  endtask

  // Drains the scoreboard one clock per entry. run drops after the first edge
  // unless keep is set; IR is scrambled after entry scr_idx (the T3 sample).
  task automatic drain(input string tag, input int scr_idx, input logic keep);
    int n = 0;
    while (q.size() != 0) begin
      @(posedge clk); #1;
      if (!keep) run = 1'b0;
      check_cycle(tag, q.pop_front());
      if (n == scr_idx) ir = 32'hDEADBEEF;
      n++;
    end
  endtask

  task automatic do_instr(input string tag, input logic [31:0] instr, input logic c);
    int mw;
    mw  = sel ? 3 : 1;
    ir  = instr;
    con = c;
    expect_instr(instr[31:27], mw, c, 0);
    run = 1'b1;
    drain(tag, mw + 2, 1'b0);
  endtask

  task automatic pulse_clr();
    run = 1'b0;
    clr = 1'b1;
    #3;
    clr = 1'b0;
  endtask

  initial begin
    exp_t idle_e;
    idle_e = {27'd0, 5'd1, S_IDLE, 1'b0};

    // Reset state, both instances
    #1;
    sel = 1'b0; check_cycle("reset_a", idle_e);
    sel = 1'b1; check_cycle("reset_b", idle_e);
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    for (int i = 0; i < 10; i++) push(27'd0, 5'd1, S_IDLE);
    drain("idle_run0", -1, 1'b0);

    // Single-cycle-memory instance
    do_instr("addi", 32'h61200044, 1'b0);
    do_instr("add",  32'h18000000, 1'b0);
    do_instr("sub",  32'h20000000, 1'b0);
    do_instr("and",  32'h28000000, 1'b0);
    do_instr("or",   32'h30000000, 1'b0);
    do_instr("andi", 32'h68000000, 1'b0);
    do_instr("ori",  32'h70000000, 1'b0);
    do_instr("ldi",  32'h08000000, 1'b0);
    do_instr("ld1",  32'h00000000, 1'b0);
    do_instr("st",   32'h10000000, 1'b0);
    do_instr("br_c0", 32'h98000000, 1'b0);
    do_instr("br_c1", 32'h98000000, 1'b1);
    do_instr("jr",   32'hA0000000, 1'b0);
    do_instr("in",   32'hB0000000, 1'b0);
    do_instr("out",  32'hB8000000, 1'b0);
    do_instr("mfhi", 32'hC0000000, 1'b0);
    do_instr("mflo", 32'hC8000000, 1'b0);
    do_instr("nop",  32'hD0000000, 1'b0);
    do_instr("undef", 32'hF8000000, 1'b0);
    do_instr("mul",  32'h78000000, 1'b0);
    do_instr("div",  32'h80000000, 1'b0);

    // Three-cycle-memory instance
    sel = 1'b1;
    do_instr("ld3",  32'h00000000, 1'b0);
    do_instr("st3",  32'h10000000, 1'b0);
    do_instr("addi3", 32'h61200044, 1'b0);
    sel = 1'b0;

    // run held high at instruction end -> straight back into T0
    ir = 32'h61200044;
    expect_instr(5'b01100, 1, 1'b0, 1);
    run = 1'b1;
    drain("addi_cont", -1, 1'b1);
    pulse_clr();

    // clr during T4 of add: outputs clear before the next edge
    ir = 32'h18000000;
    expect_instr(5'b00011, 1, 1'b0, 2);
    void'(q.pop_back());  // drop T5; abort happens in T4
    run = 1'b1;
    drain("add_pre_abort", -1, 1'b1);
    #2 clr = 1'b1;
    #1 check_cycle("clr_mid_t4", idle_e);
    #2 clr = 1'b0;
    run = 1'b0;

    // halt: frozen for 20 cycles with run held high
    ir = 32'hD8000000;
    expect_instr(5'b11011, 1, 1'b0, 2);
    for (int i = 0; i < 20; i++) push(27'd0, 5'd1, S_HALT);
    run = 1'b1;
    drain("halt", -1, 1'b1);
    pulse_clr();
    #1 check_cycle("after_halt_clr", idle_e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
